// File: rtl/hall_res_if.sv
// hall_res_if: result handshake between the Hall scan scheduler and its consumer
// Signals: valid/ready handshake, id = motor index of the result, cnt = edge count.
// Modports: master drives the result (scheduler), slave accepts it (consumer).
interface hall_res_if #(
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
);
    logic             valid;
    logic             ready;
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] cnt;
    modport master (output valid, id, cnt, input ready);
    modport slave  (input valid, id, cnt, output ready);
endinterface

// File: rtl/hall_scan_scheduler.sv
// hall_scan_scheduler: round-robin Hall edge-rate measurement sharing one window timer and one edge counter
// Ports: clk/rst   clock and synchronous active-high reset
//        en_i      scan enable
//        h_all_i   raw asynchronous Hall pins, motor i on bits [3i+2:3i]
//        res       result handshake (valid/ready, id, cnt), master side
//        speed_o   last accepted count per motor, motor i on bits [CNT_W*i +: CNT_W]
//        ovf_o     sticky per-motor flag: a window count saturated
//        busy_o    scheduler not idle
module hall_scan_scheduler #(
    parameter int N_MOTORS = 4,
    parameter int WINDOW   = 1250,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic [3*N_MOTORS-1:0]     h_all_i,
    hall_res_if.master                res,
    output logic [CNT_W*N_MOTORS-1:0] speed_o,
    output logic [N_MOTORS-1:0]       ovf_o,
    output logic                      busy_o
);
    localparam int IDX_W = (N_MOTORS > 1) ? $clog2(N_MOTORS) : 1;
    localparam int WIN_W = $clog2(WINDOW);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

    state_t                           state_q, state_d;
    logic [3*N_MOTORS-1:0]            h_s1_q, h_s2_q;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [2:0]                       prev_q, prev_d;
    logic [WIN_W-1:0]                 win_q, win_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [N_MOTORS-1:0]              ovf_q, ovf_d;
    logic [N_MOTORS-1:0][CNT_W-1:0]   speed_q, speed_d;
    logic [2:0]                       cur_h;
    logic                             win_last;
    logic                             xfer;

    // Only the synchronized Hall state of the motor currently being scanned is observed
    assign cur_h    = h_s2_q[3*idx_q +: 3];
    assign win_last = win_q == WIN_W'(WINDOW - 1);
    assign xfer     = (state_q == REPORT) && res.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_s1_q  <= '0;
            h_s2_q  <= '0;
            idx_q   <= '0;
            prev_q  <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
            speed_q <= '0;
        end else begin
            state_q <= state_d;
            h_s1_q  <= h_all_i;
            h_s2_q  <= h_s1_q;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            speed_q <= speed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = en_i ? SETTLE : IDLE;
            SETTLE:  state_d = MEASURE;
            MEASURE: state_d = win_last ? REPORT : MEASURE;
            REPORT:  state_d = res.ready ? (en_i ? SETTLE : IDLE) : REPORT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o    = state_q != IDLE;
        res.valid = state_q == REPORT;
        res.id    = idx_q;
        res.cnt   = cnt_q;
        speed_o   = speed_q;
        ovf_o     = ovf_q;
    end

    // Counter is frozen outside MEASURE, so the reported count stays stable under backpressure
    always_comb begin
        idx_d   = idx_q;
        prev_d  = prev_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        speed_d = speed_q;
        if (state_q == SETTLE) begin
            prev_d = cur_h;
            win_d  = '0;
            cnt_d  = '0;
        end
        if (state_q == MEASURE) begin
            prev_d = cur_h;
            win_d  = win_q + 1'b1;
            if (cur_h != prev_q) begin
                if (cnt_q == {CNT_W{1'b1}})
                    ovf_d[idx_q] = 1'b1;
                else
                    cnt_d = cnt_q + 1'b1;
            end
        end
        if (xfer) begin
            speed_d[idx_q] = cnt_q;
            idx_d          = (idx_q == IDX_W'(N_MOTORS - 1)) ? '0 : idx_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hall_scan_scheduler.sv
// tb_hall_scan_scheduler: randomized check of the Hall scan scheduler against a timeline reference model
module tb_hall_scan_scheduler;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int CW   = 4;
    localparam int MAXE = 8192;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_i;
    logic [3*N-1:0]    h_all_i;
    logic [CW*N-1:0]   speed_o;
    logic [N-1:0]      ovf_o;
    logic              busy_o;

    hall_res_if #(.ID_W(2), .CNT_W(CW)) res();

    hall_scan_scheduler #(.N_MOTORS(N), .WINDOW(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_i),
        .h_all_i (h_all_i),
        .res     (res),
        .speed_o (speed_o),
        .ovf_o   (ovf_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int p;
    logic [3*N-1:0] hv [MAXE];
    bit             rv [MAXE];
    logic [3*N-1:0] hcur;

    bit     m_idle;
    bit     m_valid;
    int     m_settle;
    int     m_idx;
    int     m_cnt;
    int     m_speed [N];
    logic [N-1:0] m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, p, got, exp);
        end
    endtask

    // Hall state of motor m seen by the scheduler at edge q: the pin value two edges earlier,
    // or zero while the two-stage synchronizer is still flushed by a reset
    function automatic logic [2:0] syn(input int q, input int m);
        return rv[q-1] ? 3'd0 : hv[q-2][3*m +: 3];
    endfunction

    task automatic model(input bit r, input bit e, input bit rd);
        int raw;
        if (r) begin
            m_idle   = 1'b1;
            m_valid  = 1'b0;
            m_settle = -1;
            m_idx    = 0;
            m_ovf    = '0;
            foreach (m_speed[m]) m_speed[m] = 0;
        end else if (m_idle) begin
            if (e) begin
                m_idle   = 1'b0;
                m_settle = p + 1;
            end
        end else if (m_valid) begin
            if (rd) begin
                m_speed[m_idx] = m_cnt;
                m_idx          = (m_idx + 1) % N;
                m_valid        = 1'b0;
                if (e) m_settle = p + 1;
                else begin
                    m_idle   = 1'b1;
                    m_settle = -1;
                end
            end
        end else if (p == m_settle + W) begin
            raw = 0;
            for (int q = m_settle + 1; q <= p; q++)
                if (syn(q, m_idx) != syn(q - 1, m_idx)) raw++;
            m_cnt = (raw > CMAX) ? CMAX : raw;
            if (raw > CMAX) m_ovf[m_idx] = 1'b1;
            m_valid = 1'b1;
        end
    endtask

    task automatic tick(input bit r, input bit e, input bit rd, input logic [3*N-1:0] h);
        rst       = r;
        en_i      = e;
        res.ready = rd;
        h_all_i   = h;
        @(posedge clk);
        p++;
        hv[p] = r ? '0 : h;
        rv[p] = r;
        model(r, e, rd);
        #1;
        chk("res_valid", res.valid, m_valid);
        chk("busy", busy_o, !m_idle);
        for (int m = 0; m < N; m++) chk($sformatf("speed%0d", m), speed_o[CW*m +: CW], m_speed[m]);
        if (m_valid || m_idle) chk("ovf", ovf_o, m_ovf);
        if (m_valid || r) chk("res_id", res.id, m_idx);
        if (m_valid) chk("res_cnt", res.cnt, m_cnt);
    endtask

    task automatic run(input int n, input int en_pct, input int rdy_pct,
                       input int r0, input int r1, input int r2, input int r3, input int rst_at);
        int rate [N];
        rate = '{r0, r1, r2, r3};
        for (int c = 0; c < n; c++) begin
            for (int m = 0; m < N; m++)
                if ($urandom_range(99) < rate[m]) hcur[3*m +: 3] ^= 3'($urandom_range(7, 1));
            tick(c == rst_at, $urandom_range(99) < en_pct, $urandom_range(99) < rdy_pct, hcur);
        end
    endtask

    initial begin
        p     = 1;
        hv[0] = '0;
        hv[1] = '0;
        rv[0] = 1'b1;
        rv[1] = 1'b1;
        hcur  = '0;
        for (int i = 0; i < 2; i++) begin
            hcur ^= 12'($urandom);
            tick(1'b1, 1'b1, 1'b1, hcur);
        end
        run(3,   0,   100, 0,  0,  0,   0,  -1);
        run(400, 100, 75,  5,  10, 15,  20, -1);
        run(300, 100, 10,  20, 20, 20,  20, -1);
        run(300, 80,  60,  10, 10, 10,  10, -1);
        run(200, 100, 100, 2,  2,  100, 2,  -1);
        run(150, 100, 70,  10, 10, 10,  10, 70);
        run(60,  0,   100, 10, 10, 10,  10, -1);
        tick(1'b1, 1'b0, 1'b0, hcur);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
